fetch_pc_gen: RTL

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

---
 rtl/fetch_pc_gen.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: instruction-fetch PC generator with ICache request handshake,
// epoch tagging for stale-response rejection and outstanding-request credit.
// Optional feature: define FETCH_PC_GEN_NLP_EN to let nlp_valid/nlp_target
// steer the PC after a firing request (lowest priority after backend/IF3).
module fetch_pc_gen #(
  parameter int unsigned FETCH_WIDTH     = 4,
  parameter int unsigned MAX_OUTSTANDING = 3,
  parameter logic [31:0] RESET_PC        = 32'hBFC00000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pause,
  input  logic                   be_redirect_valid,
  input  logic [31:0]            be_redirect_pc,
  input  logic                   if3_redirect_valid,
  input  logic [31:0]            if3_redirect_pc,
  input  logic                   nlp_valid,
  input  logic [31:0]            nlp_target,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [31:0]            req_pc,
  output logic [FETCH_WIDTH-1:0] req_mask,
  output logic [1:0]             req_epoch,
  input  logic                   resp_valid,
  input  logic [1:0]             resp_epoch,
  output logic                   resp_drop,
  output logic [2:0]             outstanding
);

  localparam int unsigned IDX_W       = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam logic [31:0] BLOCK_BYTES = 32'(FETCH_WIDTH * 4);
  localparam logic [2:0]  MAX_OUT     = 3'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_CREDIT
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [1:0]       epoch_q, epoch_d;
  logic [2:0]       out_q, out_d;
  logic             fire;
  logic             resp_take;
  logic [IDX_W-1:0] slot;

`ifndef FETCH_PC_GEN_NLP_EN
  logic nlp_unused;
  assign nlp_unused = ^{nlp_valid, nlp_target};
`endif

  assign fire      = req_valid && req_ready;
  // A response with nothing outstanding has no request to retire.
  assign resp_take = resp_valid && (out_q != '0);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: IDLE lasts one cycle; credit state follows next outstanding count.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:        state_d = S_FETCH;
      S_FETCH:       if (out_d >= MAX_OUT) state_d = S_WAIT_CREDIT;
      S_WAIT_CREDIT: if (out_d < MAX_OUT)  state_d = S_FETCH;
      default:       state_d = S_IDLE;
    endcase
  end

  // Output decode: request gating and stale-response detection.
  always_comb begin
    req_valid = (state_q == S_FETCH) && !pause && (out_q < MAX_OUT);
    resp_drop = rst && resp_valid && (resp_epoch != epoch_q);
  end

  // Next PC/epoch: backend > IF3 > (NLP or sequential) on fire.
  always_comb begin
    pc_d    = pc_q;
    epoch_d = epoch_q;
    if (be_redirect_valid) begin
      pc_d    = be_redirect_pc & ~32'h3;
      epoch_d = epoch_q + 2'd1;
    end else if (if3_redirect_valid) begin
      pc_d    = if3_redirect_pc & ~32'h3;
      epoch_d = epoch_q + 2'd1;
    end else if (fire) begin
`ifdef FETCH_PC_GEN_NLP_EN
      if (nlp_valid) pc_d = nlp_target & ~32'h3;
      else
`endif
      pc_d = (pc_q & ~(BLOCK_BYTES - 32'd1)) + BLOCK_BYTES;
    end
  end

  // Outstanding credit: fire and retire in the same cycle cancel out.
  always_comb begin
    out_d = out_q;
    if (fire && !resp_take && (out_q < MAX_OUT)) out_d = out_q + 3'd1;
    else if (!fire && resp_take)                 out_d = out_q - 3'd1;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      epoch_q <= '0;
      out_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
      out_q   <= out_d;
    end
  end

  // Slot mask: slots before the PC's position in its aligned block are invalid.
  assign slot = (FETCH_WIDTH > 1) ? pc_q[2 +: IDX_W] : '0;

  always_comb begin
    req_mask = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      req_mask[i] = (i >= 32'(slot));
    end
  end

  assign req_pc      = pc_q;
  assign req_epoch   = epoch_q;
  assign outstanding = out_q;

endmodule
